// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
//   AXI4-Lite initiator. It turns single-beat commands from on-chip control
//   logic into one AXI-Lite read or write transaction at a time, then returns
//   one response. There are no bursts and no pipelining.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN   clock; synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = idle)
//   cmd_write, cmd_addr,         command fields: 1 = write, byte address,
//   cmd_wdata, cmd_wstrb         write data and byte strobes
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_resp,         read data (0 for writes), RRESP/BRESP,
//   rsp_timeout                  watchdog abort flag
//   M_AXI_AW*/W*/B*/AR*/R*       AXI4-Lite master channels (no PROT signals)
//
// Optional build macro
//   AXI_MASTER_TIMEOUT_EN : adds a 16-bit watchdog. A transaction that stays
//   in WRITE or READ for TIMEOUT_CYCLES cycles is abandoned. The response then
//   carries rsp_timeout = 1 and rsp_resp = 2'b10. Without the macro, the block
//   waits indefinitely and rsp_timeout is always 0.
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              ar_done_q, ar_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   wstrb_q, wstrb_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  // A BVALID that arrives before both AW and W have completed is ignored.
  // Likewise, an RVALID that arrives before AR has completed is ignored.
  assign b_hs  = bready_q & M_AXI_BVALID & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign r_hs  = rready_q & M_AXI_RVALID & (ar_done_q | ar_hs);

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q, wdog_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  assign rsp_timeout = rsp_timeout_q;
`else
  // The watchdog limit has no effect when the watchdog is not built.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: each _d defaults to its _q first. This means no branch leaves a
    // variable unassigned, so no latch can be inferred.
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ar_done_d   = ar_done_q;
    rsp_valid_d = rsp_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXI_MASTER_TIMEOUT_EN
    wdog_d        = wdog_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          ar_done_d   = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
          wdog_d        = '0;
          rsp_timeout_d = 1'b0;
`endif
          if (cmd_write) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = S_READ;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // B can only be accepted at or after the AW and W handshakes.
        // It is therefore always the last of the three.
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_resp_d  = M_AXI_BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_READ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          ar_done_d = 1'b1;
        end
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // The watchdog expiring takes priority over a handshake in the same cycle.
    // It withdraws every channel, so later slave activity has nothing to meet.
    if (state_q == S_WRITE || state_q == S_READ) begin
      wdog_d = wdog_q + 16'd1;
      if (wdog_q == WdogLast) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = 2'b10;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b1;
        state_d       = S_RESP;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments. As a result, every
  // register samples the values from before the edge.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      wdog_q        <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ar_done_q   <= ar_done_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      wdog_q        <= wdog_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
//   Directed bench for axi_lite_master. A small register-file slave drives its
//   inputs on the falling edge. Its wait states and responses are set through
//   configuration variables. The bench checks DUT outputs on the falling edge.
//   Build with AXI_MASTER_TIMEOUT_EN defined to exercise the watchdog case.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  m_awaddr, m_araddr;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
  logic        s_arready = 1'b0, s_rvalid = 1'b0;
  logic [1:0]  s_bresp = '0, s_rresp = '0;
  logic [31:0] s_rdata = '0;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(9), .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid),
    .M_AXI_WREADY(s_wready), .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid),
    .M_AXI_BREADY(m_bready), .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid),
    .M_AXI_ARREADY(s_arready), .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp),
    .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(m_rready)
  );

  always #5 clk = ~clk;

  // ---------------- slave configuration ----------------
  int         aw_wait = 0;      // cycles AWREADY is held off
  int         w_wait = 0;       // 0: WREADY with AW; else cycles after AW handshake
  int         r_wait = 0;       // wait cycles between AR handshake and RVALID
  logic       b_early = 1'b1;   // BVALID follows BREADY, even before AW/W complete
  logic       ar_never = 1'b0;  // never assert ARREADY
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // ---------------- slave state / monitor (posedge) ----------------
  logic [31:0] mem [0:127];
  logic        rst_seen = 1'b1;
  logic        aw_acc = 1'b0, w_acc = 1'b0, ar_acc = 1'b0;
  int          aw_hi_cnt = 0, w_hi_cnt = 0, rsp_hs_cnt = 0, overlap_cnt = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic        aw_hs_w, w_hs_w, ar_hs_w, b_acc_w, r_acc_w;

  assign aw_hs_w = m_awvalid & s_awready;
  assign w_hs_w  = m_wvalid & s_wready;
  assign ar_hs_w = m_arvalid & s_arready;
  assign b_acc_w = m_bready & s_bvalid & (aw_acc | aw_hs_w) & (w_acc | w_hs_w);
  assign r_acc_w = m_rready & s_rvalid & (ar_acc | ar_hs_w);

  always @(posedge clk) begin
    rst_seen <= !rstn;
    if (!rstn) begin
      aw_acc <= 1'b0;
      w_acc  <= 1'b0;
      ar_acc <= 1'b0;
    end else begin
      if (b_acc_w) begin
        aw_acc <= 1'b0;
        w_acc  <= 1'b0;
      end else begin
        if (aw_hs_w) aw_acc <= 1'b1;
        if (w_hs_w)  w_acc  <= 1'b1;
      end
      if (r_acc_w) ar_acc <= 1'b0;
      else if (ar_hs_w) ar_acc <= 1'b1;
      if (w_hs_w)
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) mem[m_awaddr[8:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      if (m_awvalid) aw_hi_cnt <= aw_hi_cnt + 1;
      if (m_wvalid)  w_hi_cnt  <= w_hi_cnt + 1;
      if (rsp_valid && rsp_ready) rsp_hs_cnt <= rsp_hs_cnt + 1;
      if (m_awvalid && m_arvalid) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // ---------------- slave drive (negedge) ----------------
  always @(negedge clk) begin
    if (rst_seen) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
      s_arready <= 1'b0; s_rvalid <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (m_awvalid && !aw_acc) begin
        s_awready <= (aw_cnt >= aw_wait);
        aw_cnt    <= aw_cnt + 1;
      end else begin
        s_awready <= 1'b0;
        aw_cnt    <= 0;
      end
      if (m_wvalid && !w_acc && (w_wait == 0 || aw_acc)) begin
        s_wready <= (w_cnt + 1 >= w_wait);
        w_cnt    <= w_cnt + 1;
      end else begin
        s_wready <= 1'b0;
        w_cnt    <= 0;
      end
      s_bvalid <= b_early ? m_bready : (m_bready && aw_acc && w_acc);
      s_bresp  <= bresp_cfg;
      if (m_arvalid && !ar_acc && !ar_never) begin
        s_arready <= (ar_cnt >= 0);
        ar_cnt    <= ar_cnt + 1;
      end else begin
        s_arready <= 1'b0;
        ar_cnt    <= 0;
      end
      if (m_rready && ar_acc) begin
        s_rvalid <= (r_cnt >= r_wait);
        r_cnt    <= r_cnt + 1;
        s_rdata  <= (rresp_cfg == 2'b00) ? mem[m_araddr[8:2]] : 32'h0;
        s_rresp  <= rresp_cfg;
      end else begin
        s_rvalid <= 1'b0;
        r_cnt    <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on the negedge of the first cycle after command acceptance.
  // On return, it is on the negedge where rsp_valid is high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_arrived", rsp_valid, 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Issue a command from an idle DUT and collect its response.
  task automatic do_cmd(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic [1:0] rr, output logic to, output int lat);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(lat);
    rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
    take_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        to;
    int          lat, a0, w0, h0, n;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, rsp_valid}, 0);
    check("rst_readies", {m_bready, m_rready}, 0);
    check("rst_rsp", {rsp_rdata[29:0], rsp_resp, rsp_timeout}, 0);
    check("rst_addr_data", {m_awaddr, m_wdata[22:0]}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // ---- 1: zero-wait write 0x00, cycle-exact, then read back ----
    check("t1_idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h000;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    @(negedge clk);                       // N+1
    cmd_valid = 1'b0;
    check("t1_n1_cmd_ready", cmd_ready, 0);
    check("t1_n1_aw_w_b", {m_awvalid, m_wvalid, m_bready, m_arvalid}, 4'b1110);
    check("t1_n1_wdata", m_wdata, 32'hDEADBEEF);
    check("t1_n1_wstrb", m_wstrb, 4'hF);
    @(negedge clk);                       // N+2
    check("t1_n2_rsp_valid", rsp_valid, 1);
    check("t1_n2_rsp", {rsp_rdata[29:0], rsp_resp, rsp_timeout}, 0);
    check("t1_n2_chan_idle", {m_awvalid, m_wvalid, m_bready}, 0);
    take_rsp();
    check("t1_back_idle", {cmd_ready, rsp_valid}, 2'b10);
    do_cmd(1'b0, 9'h000, 32'h0, 4'h0, rd, rr, to, lat);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    check("t1_rd_resp", rr, 2'b00);
    check("t1_rd_lat", lat, 3);

    // ---- 2: WREADY 3 cycles after AWREADY; early BVALID must be ignored ----
    w_wait = 3;
    a0 = aw_hi_cnt; w0 = w_hi_cnt; h0 = rsp_hs_cnt;
    do_cmd(1'b1, 9'h004, 32'hCAFEF00D, 4'hF, rd, rr, to, lat);
    check("t2_aw_cycles", aw_hi_cnt - a0, 1);
    check("t2_w_cycles", w_hi_cnt - w0, 4);
    check("t2_lat", lat, 5);
    check("t2_resp", {rd[29:0], rr, to}, 0);
    check("t2_one_rsp", rsp_hs_cnt - h0, 1);
    w_wait = 0;

    // ---- 3: read 0x08, RRESP=10 after 5 wait cycles ----
    rresp_cfg = 2'b10; r_wait = 5;
    do_cmd(1'b0, 9'h008, 32'h0, 4'h0, rd, rr, to, lat);
    check("t3_resp", rr, 2'b10);
    check("t3_rdata", rd, 0);
    check("t3_timeout", to, 0);
    check("t3_lat", lat, 8);
    rresp_cfg = 2'b00; r_wait = 0;

    // ---- 4: rsp_ready held low 4 cycles while cmd_valid stays high ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h000;
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 9'h00C; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
    wait_rsp(lat);
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_data", rsp_rdata, 32'hDEADBEEF);
      check("t4_hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;                     // handshake cycle H
    @(negedge clk);                       // H+1
    rsp_ready = 1'b0;
    check("t4_h1_idle", {cmd_ready, rsp_valid}, 2'b10);
    @(negedge clk);                       // H+2: new command in flight
    cmd_valid = 1'b0;
    check("t4_h2_awvalid", {m_awvalid, cmd_ready}, 2'b10);
    check("t4_h2_awaddr", m_awaddr, 9'h00C);
    wait_rsp(lat);
    check("t4_wr_resp", rsp_resp, 2'b00);
    take_rsp();
    do_cmd(1'b1, 9'h00C, 32'hAABBCCDD, 4'h5, rd, rr, to, lat);
    do_cmd(1'b0, 9'h00C, 32'h0, 4'h0, rd, rr, to, lat);
    check("t4_strobe_merge", rd, 32'h12BB56DD);

    // ---- 5: reset pulse mid-write, after AW and before B ----
    w_wait = 5; b_early = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h010;
    cmd_wdata = 32'h00000055; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_mid_write", {m_awvalid, m_wvalid, m_bready}, 3'b011);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("t5_valids_zero", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("t5_idle", {cmd_ready, rsp_valid}, 2'b10);
    @(negedge clk);
    w_wait = 0; b_early = 1'b1;
    do_cmd(1'b0, 9'h004, 32'h0, 4'h0, rd, rr, to, lat);
    check("t5_recover_rd", rd, 32'hCAFEF00D);

    // ---- 6: slave never asserts ARREADY ----
    ar_never = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h014;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_arvalid) n++;
      @(negedge clk);
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    check("t6_arvalid_cycles", n, 16);
    check("t6_rsp_valid", rsp_valid, 1);
    check("t6_timeout", rsp_timeout, 1);
    check("t6_resp", rsp_resp, 2'b10);
    check("t6_rdata", rsp_rdata, 0);
    check("t6_chan_dropped", {m_arvalid, m_rready}, 0);
    take_rsp();
    check("t6_idle", cmd_ready, 1);
`else
    check("t6_arvalid_cycles", n, 100);
    check("t6_no_rsp", rsp_valid, 0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("t6_reset_clear", {m_arvalid, m_rready, cmd_ready}, 3'b001);
`endif
    ar_never = 1'b0;
    @(negedge clk);

    check("no_aw_ar_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
